// File: rtl/lerp2_sweep.sv
// Row-major grid sweeper driving a bilinear interpolator via start/done.
// Optional LERP2_SWEEP_TIMEOUT_EN aborts a sweep when done never arrives.
module lerp2_sweep #(
    parameter int WIDTH   = 32,
    parameter int FBITS   = 16,
    parameter int CW      = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CW-1:0]    cfg_nx,
    input  logic [CW-1:0]    cfg_ny,
    output logic             busy,
    output logic             cfg_err,
    output logic             lerp_start,
    output logic [WIDTH-1:0] lerp_x,
    output logic [WIDTH-1:0] lerp_y,
    output logic [WIDTH-1:0] lerp_X,
    output logic [WIDTH-1:0] lerp_Y,
    input  logic             lerp_done,
    input  logic [WIDTH-1:0] lerp_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [CW-1:0]    out_x,
    output logic [CW-1:0]    out_y,
    output logic             out_last,
    output logic             sweep_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DONE
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    nx_q, nx_d, ny_q, ny_d;
    logic [CW-1:0]    ix_q, ix_d, iy_q, iy_d;
    logic [WIDTH-1:0] lx_q, lx_d, ly_q, ly_d;
    logic [WIDTH-1:0] ov_q, ov_d;
    logic [CW-1:0]    ox_q, ox_d, oy_q, oy_d;
    logic             ol_q, ol_d;
    logic             err_q, err_d;

`ifdef LERP2_SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Zero-extend then shift; bits pushed past WIDTH are dropped.
    function automatic logic [WIDTH-1:0] fx(input logic [CW-1:0] v);
        logic [WIDTH-1:0] w;
        w = WIDTH'(v);
        return w << FBITS;
    endfunction

    always_comb begin
        state_d = state_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        ix_d    = ix_q;
        iy_d    = iy_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        ov_d    = ov_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        ol_d    = ol_q;
        err_d   = 1'b0;
`ifdef LERP2_SWEEP_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_nx < CW'(2) || cfg_ny < CW'(2)) begin
                        err_d = 1'b1;
                    end else begin
                        nx_d    = cfg_nx;
                        ny_d    = cfg_ny;
                        ix_d    = '0;
                        iy_d    = '0;
                        lx_d    = fx(cfg_nx - CW'(1));
                        ly_d    = fx(cfg_ny - CW'(1));
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef LERP2_SWEEP_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                if (lerp_done) begin
                    ov_d    = lerp_val;
                    ox_d    = ix_q;
                    oy_d    = iy_q;
                    ol_d    = (ix_q == nx_q - CW'(1)) &&
                              (iy_q == ny_q - CW'(1));
                    state_d = S_OUT;
                end
`ifdef LERP2_SWEEP_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_OUT: begin
                if (out_ready) begin
                    if (ol_q) begin
                        state_d = S_DONE;
                    end else if (ix_q == nx_q - CW'(1)) begin
                        ix_d    = '0;
                        iy_d    = iy_q + CW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        ix_d    = ix_q + CW'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            nx_q    <= '0;
            ny_q    <= '0;
            ix_q    <= '0;
            iy_q    <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            ov_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            ol_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef LERP2_SWEEP_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            ov_q    <= ov_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            ol_q    <= ol_d;
            err_q   <= err_d;
`ifdef LERP2_SWEEP_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign lerp_start = (state_q == S_ISSUE);
    assign out_valid  = (state_q == S_OUT);
    assign sweep_done = (state_q == S_DONE);
    assign cfg_err    = err_q;
    assign lerp_x     = fx(ix_q);
    assign lerp_y     = fx(iy_q);
    assign lerp_X     = lx_q;
    assign lerp_Y     = ly_q;
    assign out_val    = ov_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;
    assign out_last   = ol_q;

endmodule

// File: tb/tb_lerp2_sweep.sv
// Directed bench for lerp2_sweep with a small fixed-latency interpolator model.
// Timeout sequence runs only when LERP2_SWEEP_TIMEOUT_EN is defined.
module tb_lerp2_sweep;

    typedef struct {
        int x;
        int y;
        int val;
        int last;
    } samp_t;

    typedef struct {
        logic [15:0] nx;
        logic [15:0] ny;
    } rej_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_nx = '0;
    logic [15:0] cfg_ny = '0;
    logic        busy, cfg_err, lerp_start;
    logic [31:0] lerp_x, lerp_y, lerp_X, lerp_Y;
    logic        lerp_done = 1'b0;
    logic [31:0] lerp_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_val;
    logic [15:0] out_x, out_y;
    logic        out_last, sweep_done;

    lerp2_sweep #(
        .WIDTH(32), .FBITS(16), .CW(16), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_start(cfg_start), .cfg_nx(cfg_nx), .cfg_ny(cfg_ny),
        .busy(busy), .cfg_err(cfg_err),
        .lerp_start(lerp_start),
        .lerp_x(lerp_x), .lerp_y(lerp_y),
        .lerp_X(lerp_X), .lerp_Y(lerp_Y),
        .lerp_done(lerp_done), .lerp_val(lerp_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_val(out_val), .out_x(out_x), .out_y(out_y),
        .out_last(out_last), .sweep_done(sweep_done)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                      nm, act, act, exp, exp);
    endtask

    // Interpolator model: val = ix + 10*iy, done 4 cycles after start.
    int          m_cnt = 0;
    bit          m_pend = 0;
    bit          m_kill = 0;
    logic [31:0] m_val = '0;

    always @(negedge clock) begin
        lerp_done = 1'b0;
        if (m_pend) begin
            if (m_cnt == 0) begin
                lerp_done = 1'b1;
                lerp_val  = m_val;
                m_pend    = 0;
            end else begin
                m_cnt--;
            end
        end
        if (lerp_start && !m_kill) begin
            m_pend = 1;
            m_cnt  = 2;
            m_val  = (lerp_x >> 16) + 10 * (lerp_y >> 16);
        end
    end

    int          cyc = 0;
    int          st_n, acc_n, done_n, err_n, start_cyc, err_cyc;
    bit          valid_seen, busy_seen;
    logic [31:0] sx[16];
    logic [31:0] sy[16];
    int          ax[16], ay[16], av[16], al[16];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (lerp_start) begin
            if (st_n < 16) begin
                sx[st_n] = lerp_x;
                sy[st_n] = lerp_y;
            end
            st_n++;
            start_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            if (acc_n < 16) begin
                ax[acc_n] = int'(out_x);
                ay[acc_n] = int'(out_y);
                av[acc_n] = int'(out_val);
                al[acc_n] = int'(out_last);
            end
            acc_n++;
        end
        if (out_valid) valid_seen = 1;
        if (busy) busy_seen = 1;
        if (sweep_done) done_n++;
        if (cfg_err) begin
            err_n++;
            err_cyc = cyc;
        end
    end

    task automatic clr();
        st_n = 0; acc_n = 0; done_n = 0; err_n = 0;
        valid_seen = 0; busy_seen = 0;
    endtask

    task automatic cfg(input logic [15:0] nx, input logic [15:0] ny);
        @(posedge clock); #1;
        cfg_start = 1'b1; cfg_nx = nx; cfg_ny = ny;
        @(posedge clock); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clock); #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({nm, "_end_timeout"}, 0, 1);
    endtask

    task automatic chk_samp(input string nm, input int i, input samp_t e);
        chk($sformatf("%s_s%0d_x", nm, i), ax[i], e.x);
        chk($sformatf("%s_s%0d_y", nm, i), ay[i], e.y);
        chk($sformatf("%s_s%0d_val", nm, i), av[i], e.val);
        chk($sformatf("%s_s%0d_last", nm, i), al[i], e.last);
    endtask

    samp_t t32[6];
    samp_t t22[4];
    rej_t  trej[4];
    int    ex32[6];
    int    ey32[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        t32[0] = '{0, 0, 0, 0};
        t32[1] = '{1, 0, 1, 0};
        t32[2] = '{2, 0, 2, 0};
        t32[3] = '{0, 1, 10, 0};
        t32[4] = '{1, 1, 11, 0};
        t32[5] = '{2, 1, 12, 1};
        t22[0] = '{0, 0, 0, 0};
        t22[1] = '{1, 0, 1, 0};
        t22[2] = '{0, 1, 10, 0};
        t22[3] = '{1, 1, 11, 1};
        ex32   = '{0, 'h10000, 'h20000, 0, 'h10000, 'h20000};
        ey32   = '{0, 0, 0, 'h10000, 'h10000, 'h10000};
        trej[0] = '{16'd1, 16'd4};
        trej[1] = '{16'd4, 16'd1};
        trej[2] = '{16'd0, 16'd5};
        trej[3] = '{16'd1, 16'd1};
        clr();

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_start", lerp_start, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_X", lerp_X, 0);
        chk("rst_val", out_val, 0);

        // Basic 3x2 sweep, ready always high
        clr();
        cfg(16'd3, 16'd2);
        chk("a_X", lerp_X, 'h20000);
        chk("a_Y", lerp_Y, 'h10000);
        wait_idle("a", 400);
        chk("a_count", acc_n, 6);
        for (int i = 0; i < 6; i++) chk_samp("a", i, t32[i]);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("a_lx%0d", i), sx[i], ex32[i]);
            chk($sformatf("a_ly%0d", i), sy[i], ey32[i]);
        end
        chk("a_sweep_done", done_n, 1);
        chk("a_err", err_n, 0);

        // Backpressure on the second sample
        clr();
        cfg(16'd3, 16'd2);
        begin
            bit hit;
            hit = 0;
            for (int k = 0; k < 200; k++) begin
                @(posedge clock); #1;
                if (out_valid && acc_n == 1) begin
                    hit = 1;
                    break;
                end
            end
            out_ready = 1'b0;
            chk("b_reach_s2", hit, 1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clock);
                chk($sformatf("b_hold_valid%0d", k), out_valid, 1);
                chk($sformatf("b_hold_val%0d", k), out_val, 1);
                chk($sformatf("b_hold_x%0d", k), out_x, 1);
            end
            chk("b_no_issue", st_n, 2);
            @(posedge clock); #1;
            out_ready = 1'b1;
        end
        wait_idle("b", 400);
        chk("b_count", acc_n, 6);
        for (int i = 0; i < 6; i++) chk_samp("b", i, t32[i]);
        chk("b_sweep_done", done_n, 1);

        // Size rejection
        for (int i = 0; i < 4; i++) begin
            clr();
            cfg(trej[i].nx, trej[i].ny);
            repeat (3) @(posedge clock);
            #1;
            chk($sformatf("r%0d_err", i), err_n, 1);
            chk($sformatf("r%0d_busy", i), busy_seen, 0);
            chk($sformatf("r%0d_start", i), st_n, 0);
        end

        // Reset while waiting on sample 3
        clr();
        cfg(16'd3, 16'd2);
        begin
            bit hit;
            hit = 0;
            for (int k = 0; k < 200; k++) begin
                @(posedge clock); #1;
                if (st_n == 3) begin
                    hit = 1;
                    break;
                end
            end
            chk("c_reach_s3", hit, 1);
        end
        reset = 1'b1;
        valid_seen = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        chk("c_busy", busy, 0);
        chk("c_valid_seen", valid_seen, 0);
        chk("c_X", lerp_X, 0);
        chk("c_Y", lerp_Y, 0);
        chk("c_lx", lerp_x, 0);
        chk("c_val", out_val, 0);
        chk("c_acc", acc_n, 2);
        chk("c_done", done_n, 0);
        clr();
        cfg(16'd2, 16'd2);
        wait_idle("c2", 300);
        chk("c2_count", acc_n, 4);
        for (int i = 0; i < 4; i++) chk_samp("c2", i, t22[i]);
        chk("c2_sweep_done", done_n, 1);

        // cfg_start while busy and in the DONE cycle
        clr();
        cfg(16'd2, 16'd2);
        repeat (4) @(posedge clock);
        #1;
        cfg_start = 1'b1; cfg_nx = 16'd5; cfg_ny = 16'd7;
        @(posedge clock); #1;
        cfg_start = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int k = 0; k < 300; k++) begin
                @(posedge clock); #1;
                if (sweep_done) begin
                    hit = 1;
                    break;
                end
            end
            chk("d_reach_done", hit, 1);
        end
        chk("d_X", lerp_X, 'h10000);
        chk("d_Y", lerp_Y, 'h10000);
        cfg_start = 1'b1; cfg_nx = 16'd2; cfg_ny = 16'd2;
        @(posedge clock); #1;
        cfg_start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("d_busy_after", busy, 0);
        chk("d_starts", st_n, 4);
        chk("d_count", acc_n, 4);
        for (int i = 0; i < 4; i++) chk_samp("d", i, t22[i]);
        chk("d_err", err_n, 0);
        chk("d_sweep_done", done_n, 1);

`ifdef LERP2_SWEEP_TIMEOUT_EN
        // Interpolator never answers
        clr();
        m_kill = 1;
        cfg(16'd2, 16'd2);
        wait_idle("t", 100);
        repeat (2) @(posedge clock);
        #1;
        chk("t_err", err_n, 1);
        chk("t_err_delay", err_cyc - start_cyc, 9);
        chk("t_busy", busy, 0);
        chk("t_valid_seen", valid_seen, 0);
        chk("t_sweep_done", done_n, 0);
        m_kill = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
